// File: rtl/alu_issue_stage.sv
// DLX ID/EX issue stage: decodes ALU ops, builds operands, 2-entry skid buffer.
// Optional operand forwarding is enabled with `define ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_opcode,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } uop_t;

    uop_t        dec;
    uop_t        mem [2];
    logic        head;
    logic [1:0]  count;
    logic        tail;
    logic        push;
    logic        pop;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [5:0]  op;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic        legal;

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_hit1;
    logic fwd_hit2;
    assign fwd_hit1 = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[25:21]);
    assign fwd_hit2 = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[20:16]);
    assign rs1_v = fwd_hit1 ? fwd_data : rs1_data;
    assign rs2_v = fwd_hit2 ? fwd_data : rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
    assign rs1_v = rs1_data;
    assign rs2_v = rs2_data;
`endif

    assign op    = instr[31:26];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'h0000, instr[15:0]};

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        dec.a  = rs1_v;
        dec.rd = instr[20:16];
        case (op)
            6'h00: begin
                dec.opc = instr[5:0];
                dec.b   = rs2_v;
                dec.rd  = instr[15:11];
                case (instr[5:0]) inside
                    6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22,
                    6'h24, 6'h25, 6'h26,
                    [6'h28:6'h2e]: legal = 1'b1;
                    default:       legal = 1'b0;
                endcase
            end
            6'h08: begin dec.opc = 6'h21; dec.b = imm_s; end
            6'h09: begin dec.opc = 6'h21; dec.b = imm_z; end
            6'h0a: begin dec.opc = 6'h22; dec.b = imm_s; end
            6'h0b: begin dec.opc = 6'h22; dec.b = imm_z; end
            6'h0c: begin dec.opc = 6'h24; dec.b = imm_z; end
            6'h0d: begin dec.opc = 6'h25; dec.b = imm_z; end
            6'h0e: begin dec.opc = 6'h26; dec.b = imm_z; end
            6'h0f: begin dec.opc = 6'h2e; dec.b = imm_z; end
            6'h14: begin dec.opc = 6'h04; dec.b = imm_z; end
            6'h16: begin dec.opc = 6'h06; dec.b = imm_z; end
            6'h17: begin dec.opc = 6'h07; dec.b = imm_z; end
            6'h18: begin dec.opc = 6'h28; dec.b = imm_s; end
            6'h19: begin dec.opc = 6'h29; dec.b = imm_s; end
            6'h1a: begin dec.opc = 6'h2a; dec.b = imm_s; end
            6'h1b: begin dec.opc = 6'h2b; dec.b = imm_s; end
            6'h1c: begin dec.opc = 6'h2c; dec.b = imm_s; end
            6'h1d: begin dec.opc = 6'h2d; dec.b = imm_s; end
            default: legal = 1'b0;
        endcase
        // Illegal ops still flow, but as a harmless ADD 0,0 with no writeback
        if (!legal) begin
            dec.a   = '0;
            dec.b   = '0;
            dec.opc = 6'h20;
            dec.rd  = '0;
            dec.ill = 1'b1;
        end
        dec.we = legal && (dec.rd != 5'd0);
    end

    assign in_ready = (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;
    assign tail = head ^ count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            head   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= dec;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign alu_a       = mem[head].a;
    assign alu_b       = mem[head].b;
    assign alu_opcode  = mem[head].opc;
    assign out_rd      = mem[head].rd;
    assign out_we      = mem[head].we;
    assign out_illegal = mem[head].ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus randomized traffic
// checked against a decode model written from the instruction-set rules.
module tb_alu_issue_stage;

    logic        clk = 0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_opcode;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rnd_ready = 0;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic fv,
                                   input logic [4:0] frd, input logic [31:0] fd);
        exp_t e;
        int   o;
        int   f;
        logic [31:0] sx;
        logic [31:0] zx;
        bit   ok;
        o  = int'(ins[31:26]);
        f  = int'(ins[5:0]);
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
`ifdef ALU_ISSUE_FWD_EN
        if (fv && frd != 0 && frd == ins[25:21]) r1 = fd;
        if (fv && frd != 0 && frd == ins[20:16]) r2 = fd;
`endif
        e = '0;
        ok = 1;
        e.a = r1;
        e.rd = ins[20:16];
        if (o == 0) begin
            ok = (f == 4 || f == 6 || f == 7 || f == 'h20 || f == 'h21 || f == 'h22
                  || f == 'h24 || f == 'h25 || f == 'h26 || (f >= 'h28 && f <= 'h2e));
            e.opc = 6'(f);
            e.b = r2;
            e.rd = ins[15:11];
        end else if (o == 8 || o == 9) begin
            e.opc = 6'h21; e.b = (o == 8) ? sx : zx;
        end else if (o == 'h0a || o == 'h0b) begin
            e.opc = 6'h22; e.b = (o == 'h0a) ? sx : zx;
        end else if (o >= 'h0c && o <= 'h0e) begin
            e.opc = 6'(o + 'h18); e.b = zx;
        end else if (o == 'h0f) begin
            e.opc = 6'h2e; e.b = zx;
        end else if (o == 'h14 || o == 'h16 || o == 'h17) begin
            e.opc = 6'(o - 'h10); e.b = zx;
        end else if (o >= 'h18 && o <= 'h1d) begin
            e.opc = 6'(o + 'h10); e.b = sx;
        end else begin
            ok = 0;
        end
        if (!ok) begin
            e.a = 0; e.b = 0; e.opc = 6'h20; e.ill = 1;
        end
        e.we = ok && (e.rd != 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: pop and compare whenever the DUT hands an op downstream
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_op: got opc %h a %h b %h want none",
                             alu_opcode, alu_a, alu_b);
                end else begin
                    e = q.pop_front();
                    if (alu_a !== e.a || alu_b !== e.b || alu_opcode !== e.opc ||
                        out_we !== e.we || out_illegal !== e.ill ||
                        (!e.ill && out_rd !== e.rd)) begin
                        n_bad++;
                        $display("FAIL op: got a %h b %h opc %h rd %0d we %b ill %b want a %h b %h opc %h rd %0d we %b ill %b",
                                 alu_a, alu_b, alu_opcode, out_rd, out_we, out_illegal,
                                 e.a, e.b, e.opc, e.rd, e.we, e.ill);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom % 2);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic fv, input logic [4:0] frd, input logic [31:0] fd,
                         input exp_t e);
        int n = 0;
        in_valid = 1; instr = ins; rs1_data = r1; rs2_data = r2;
        fwd_valid = fv; fwd_rd = frd; fwd_data = fd;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
        end else begin
            q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 0; fwd_valid = 0;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        offer(ins, r1, r2, 0, 0, 0, model(ins, r1, r2, 0, 0, 0));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_left", q.size(), 0);
        chk("drain_valid", {31'b0, out_valid}, 0);
    endtask

    initial begin
        exp_t e;
        exp_t ea;
        logic [31:0] ins;
        logic [5:0] rf[16] = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
                               6'h26, 6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2c, 6'h2d, 6'h2e};
        logic [5:0] io[17] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                               6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h1c, 6'h1d};
        rst = 1; flush = 0; in_valid = 0; instr = 0; rs1_data = 0; rs2_data = 0;
        fwd_valid = 0; fwd_rd = 0; fwd_data = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_ready", {31'b0, in_ready}, 1);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_opc", {26'b0, alu_opcode}, 0);
        chk("rst_rd", {27'b0, out_rd}, 0);
        chk("rst_we", {31'b0, out_we}, 0);
        chk("rst_ill", {31'b0, out_illegal}, 0);

        out_ready = 1;
        offer(32'h00221820, 5, 7, 0, 0, 0, '{a: 5, b: 7, opc: 6'h20, rd: 3, we: 1, ill: 0});
        offer(32'h2024FFFF, 9, 0, 0, 0, 0,
              '{a: 9, b: 32'hFFFFFFFF, opc: 6'h21, rd: 4, we: 1, ill: 0});
        offer(32'h2424FFFF, 9, 0, 0, 0, 0,
              '{a: 9, b: 32'h0000FFFF, opc: 6'h21, rd: 4, we: 1, ill: 0});
        offer(32'h68258000, 3, 0, 0, 0, 0,
              '{a: 3, b: 32'hFFFF8000, opc: 6'h2a, rd: 5, we: 1, ill: 0});
        offer(32'hFC221820, 3, 4, 0, 0, 0,
              '{a: 0, b: 0, opc: 6'h20, rd: 0, we: 0, ill: 1});
`ifdef ALU_ISSUE_FWD_EN
        offer(32'h00221820, 5, 7, 1, 1, 32'hDEAD,
              '{a: 32'hDEAD, b: 7, opc: 6'h20, rd: 3, we: 1, ill: 0});
`else
        offer(32'h00221820, 5, 7, 1, 1, 32'hDEAD,
              '{a: 5, b: 7, opc: 6'h20, rd: 3, we: 1, ill: 0});
`endif
        offer(32'h00201820, 5, 7, 1, 0, 32'hBEEF,
              '{a: 5, b: 7, opc: 6'h20, rd: 3, we: 1, ill: 0});
        drain();

        // Backpressure: two accepts fill the pair, third is held off
        out_ready = 0;
        ea = model(32'h00221820, 1, 2, 0, 0, 0);
        send(32'h00221820, 1, 2);
        send(32'h00432022, 3, 4);
        in_valid = 1; instr = 32'h20A6_1234; rs1_data = 6; rs2_data = 0;
        repeat (3) begin
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            chk("bp_hold_b", alu_b, ea.b);
            @(posedge clk); #1;
        end
        out_ready = 1;
        send(32'h20A6_1234, 6, 0);
        drain();

        // Flush with both entries full and an offer pending
        out_ready = 0;
        send(32'h00221820, 1, 2);
        send(32'h00432022, 3, 4);
        in_valid = 1; instr = 32'h00221820; flush = 1;
        q.delete();
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush_valid", {31'b0, out_valid}, 0);
        chk("flush_ready", {31'b0, in_ready}, 1);
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;

        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            logic fv;
            logic [4:0] frd;
            logic [31:0] fd, r1, r2;
            ins = $urandom;
            case ($urandom % 4)
                0: begin ins[31:26] = 0; ins[5:0] = rf[$urandom % 16]; end
                1: ins[31:26] = 0;
                2: ins[31:26] = io[$urandom % 17];
                default: ;
            endcase
            if ($urandom % 2) begin
                ins[25:21] = 5'($urandom % 4);
                ins[20:16] = 5'($urandom % 4);
            end
            fv = 1'($urandom % 2); frd = 5'($urandom % 4); fd = $urandom;
            r1 = $urandom; r2 = $urandom;
            e = model(ins, r1, r2, fv, frd, fd);
            offer(ins, r1, r2, fv, frd, fd, e);
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_ready = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
